// File: rtl/iob_sim_mii_loopback.sv
// Simulation-side MII loopback partner: divides clk_i down to an MII clock,
// captures complete TX frames into a nibble FIFO and replays them on RX after
// a programmable inter-frame gap, with pass / drop / corrupt modes.
// Ports:
//   clk_i, arst_n_i       system clock, async active-low reset
//   mode_i                0/3 loopback, 1 drop all, 2 corrupt last nibble bit0
//   ifg_i                 idle MII cycles before each replayed frame (0 -> 1)
//   eth_clk_o             MII clock towards the DUT
//   tx_en_i, tx_data_i    DUT transmit side
//   rx_dv_o, rx_data_o    DUT receive side
//   frames_rx_o/tx_o/drop_o  frame statistics
//   busy_o                FIFO holds a committed frame, replay or capture active
module iob_sim_mii_loopback #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned FIFO_ADDR_W = 11,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       ifg_i,
  output logic             eth_clk_o,
  input  logic             tx_en_i,
  input  logic [3:0]       tx_data_i,
  output logic             rx_dv_o,
  output logic [3:0]       rx_data_o,
  output logic [CNT_W-1:0] frames_rx_o,
  output logic [CNT_W-1:0] frames_tx_o,
  output logic [CNT_W-1:0] frames_drop_o,
  output logic             busy_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned DEPTH = 1 << FIFO_ADDR_W;
  localparam int unsigned PTR_W = FIFO_ADDR_W + 1;
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [1:0] MODE_DROP    = 2'd1;
  localparam logic [1:0] MODE_CORRUPT = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SEND} state_e;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             eth_clk_q, eth_clk_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] commit_q, commit_d, frame_start_q, frame_start_d;
  logic             capturing_q, capturing_d, bad_q, bad_d;
  logic             drop_frame_q, drop_frame_d, armed_q, armed_d;
  logic [3:0]       last_nib_q, last_nib_d;
  state_e           state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic             sent_last_q, sent_last_d;
  logic             rx_dv_q, rx_dv_d;
  logic [3:0]       rx_data_q, rx_data_d;
  logic [CNT_W-1:0] frames_rx_q, frames_rx_d, frames_tx_q, frames_tx_d;
  logic [CNT_W-1:0] frames_drop_q, frames_drop_d;
  logic             busy_q, busy_d;

  // Entry = {last, nibble}
  logic [4:0]             mem_q [DEPTH];
  logic                   mem_we_c;
  logic [FIFO_ADDR_W-1:0] mem_waddr_c;
  logic [4:0]             mem_wdata_c;
  logic [4:0]             rd_entry_c;
  logic                   fall_tick_c, full_c, send_c;

  assign fall_tick_c = (cnt_q == CNT_LAST);
  assign full_c      = (wr_ptr_q[FIFO_ADDR_W] != rd_ptr_q[FIFO_ADDR_W]) &&
                       (wr_ptr_q[FIFO_ADDR_W-1:0] == rd_ptr_q[FIFO_ADDR_W-1:0]);
  assign rd_entry_c  = mem_q[rd_ptr_q[FIFO_ADDR_W-1:0]];

  // Next-state logic for divider, capture side and replay FSM
  always_comb begin
    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + DIV_W'(1);
    eth_clk_d     = (cnt_d >= CNT_HALF);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    commit_d      = commit_q;
    frame_start_d = frame_start_q;
    capturing_d   = capturing_q;
    bad_d         = bad_q;
    drop_frame_d  = drop_frame_q;
    armed_d       = armed_q;
    last_nib_d    = last_nib_q;
    state_d       = state_q;
    gap_d         = gap_q;
    sent_last_d   = sent_last_q;
    rx_dv_d       = rx_dv_q;
    rx_data_d     = rx_data_q;
    frames_rx_d   = frames_rx_q;
    frames_tx_d   = frames_tx_q;
    frames_drop_d = frames_drop_q;
    mem_we_c      = 1'b0;
    mem_waddr_c   = wr_ptr_q[FIFO_ADDR_W-1:0];
    mem_wdata_c   = {1'b0, tx_data_i};
    send_c        = 1'b0;

    if (fall_tick_c) begin
      // A frame already running at reset release is skipped until TX_EN drops
      if (!tx_en_i) armed_d = 1'b1;

      if (tx_en_i && capturing_q) begin
        if (bad_q || full_c) begin
          bad_d = 1'b1;
        end else begin
          mem_we_c   = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
          last_nib_d = tx_data_i;
        end
      end else if (tx_en_i && armed_q) begin
        capturing_d   = 1'b1;
        frame_start_d = wr_ptr_q;
        drop_frame_d  = (mode_i == MODE_DROP);
        bad_d         = full_c;
        if (!full_c) begin
          mem_we_c   = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
          last_nib_d = tx_data_i;
        end
      end else if (!tx_en_i && capturing_q) begin
        capturing_d = 1'b0;
        if (bad_q || drop_frame_q) begin
          wr_ptr_d      = frame_start_q;
          frames_drop_d = frames_drop_q + CNT_W'(1);
        end else begin
          // Re-write the final nibble with its last flag, then publish the frame
          mem_we_c    = 1'b1;
          mem_waddr_c = wr_ptr_q[FIFO_ADDR_W-1:0] - FIFO_ADDR_W'(1);
          mem_wdata_c = {1'b1, last_nib_q};
          commit_d    = wr_ptr_q;
          frames_rx_d = frames_rx_q + CNT_W'(1);
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (rd_ptr_q != commit_q) begin
            state_d = ST_GAP;
            gap_d   = (ifg_i == 8'd0) ? 8'd1 : ifg_i;
          end
        end
        ST_GAP: begin
          if (gap_q == 8'd1) send_c = 1'b1;
          else               gap_d  = gap_q - 8'd1;
        end
        ST_SEND: begin
          if (sent_last_q) begin
            state_d     = ST_IDLE;
            rx_dv_d     = 1'b0;
            rx_data_d   = 4'd0;
            sent_last_d = 1'b0;
            frames_tx_d = frames_tx_q + CNT_W'(1);
          end else begin
            send_c = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Drive the nibble at rd_ptr; corruption follows the mode at send time
      if (send_c) begin
        state_d     = ST_SEND;
        rx_dv_d     = 1'b1;
        rx_data_d   = rd_entry_c[3:0] ^ {3'b000, rd_entry_c[4] && (mode_i == MODE_CORRUPT)};
        sent_last_d = rd_entry_c[4];
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end
    end

    busy_d = (rd_ptr_d != commit_d) || (state_d != ST_IDLE) || capturing_d;
  end

  // State registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q         <= '0;
      eth_clk_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      commit_q      <= '0;
      frame_start_q <= '0;
      capturing_q   <= 1'b0;
      bad_q         <= 1'b0;
      drop_frame_q  <= 1'b0;
      armed_q       <= 1'b0;
      last_nib_q    <= 4'd0;
      state_q       <= ST_IDLE;
      gap_q         <= 8'd0;
      sent_last_q   <= 1'b0;
      rx_dv_q       <= 1'b0;
      rx_data_q     <= 4'd0;
      frames_rx_q   <= '0;
      frames_tx_q   <= '0;
      frames_drop_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      eth_clk_q     <= eth_clk_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_q      <= commit_d;
      frame_start_q <= frame_start_d;
      capturing_q   <= capturing_d;
      bad_q         <= bad_d;
      drop_frame_q  <= drop_frame_d;
      armed_q       <= armed_d;
      last_nib_q    <= last_nib_d;
      state_q       <= state_d;
      gap_q         <= gap_d;
      sent_last_q   <= sent_last_d;
      rx_dv_q       <= rx_dv_d;
      rx_data_q     <= rx_data_d;
      frames_rx_q   <= frames_rx_d;
      frames_tx_q   <= frames_tx_d;
      frames_drop_q <= frames_drop_d;
      busy_q        <= busy_d;
    end
  end

  // Frame buffer storage
  always_ff @(posedge clk_i) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign eth_clk_o     = eth_clk_q;
  assign rx_dv_o       = rx_dv_q;
  assign rx_data_o     = rx_data_q;
  assign frames_rx_o   = frames_rx_q;
  assign frames_tx_o   = frames_tx_q;
  assign frames_drop_o = frames_drop_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_iob_sim_mii_loopback.sv
// Bench for iob_sim_mii_loopback: frame-level reference model (queues of
// expected nibbles), directed scenarios, a vector table and random blocks.
module tb_iob_sim_mii_loopback;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned FIFO_ADDR_W = 6;
  localparam int unsigned CNT_W       = 16;
  localparam int          DEPTH       = 1 << FIFO_ADDR_W;

  logic             clk = 1'b0;
  logic             arst_n_i;
  logic [1:0]       mode_i;
  logic [7:0]       ifg_i;
  logic             eth_clk_o;
  logic             tx_en_i;
  logic [3:0]       tx_data_i;
  logic             rx_dv_o;
  logic [3:0]       rx_data_o;
  logic [CNT_W-1:0] frames_rx_o, frames_tx_o, frames_drop_o;
  logic             busy_o;

  iob_sim_mii_loopback #(
    .CLK_DIV(CLK_DIV), .FIFO_ADDR_W(FIFO_ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .mode_i(mode_i), .ifg_i(ifg_i),
    .eth_clk_o(eth_clk_o), .tx_en_i(tx_en_i), .tx_data_i(tx_data_i),
    .rx_dv_o(rx_dv_o), .rx_data_o(rx_data_o), .frames_rx_o(frames_rx_o),
    .frames_tx_o(frames_tx_o), .frames_drop_o(frames_drop_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int mii_n = 0;
  bit in_frame = 1'b0;
  logic [3:0] cur_q[$];
  logic [3:0] exp_nib[$];
  int exp_len[$];
  int last_first_mii;
  logic [3:0] last_rx_nib;
  int exp_rx = 0, exp_tx = 0, exp_drop = 0;
  logic [3:0] fb [256];
  int flen;
  int t_end;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] ifg;
    int         len;
    logic [3:0] last_nib;
    int         exp_lat;
    logic [3:0] exp_last;
    bit         exp_replay;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One MII cycle: ends just after the edge where the DUT samples TX / drives RX
  task automatic mii_cycle();
    int n;
    int errs;
    logic [3:0] e;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    mii_n++;
    if (rx_dv_o) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        last_first_mii = mii_n;
      end
      cur_q.push_back(rx_data_o);
    end else if (in_frame) begin
      in_frame = 1'b0;
      last_rx_nib = cur_q[cur_q.size()-1];
      if (exp_len.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got %0d nibbles, required no frame", cur_q.size());
      end else begin
        n = exp_len.pop_front();
        check("frame_len", 32'(cur_q.size()), 32'(n));
        errs = 0;
        for (int i = 0; i < n; i++) begin
          e = exp_nib.pop_front();
          if (i >= cur_q.size() || cur_q[i] !== e) errs++;
        end
        check("frame_data_errors", 32'(errs), 32'd0);
        exp_tx++;
      end
      cur_q.delete();
    end
  endtask

  // Drive fb[0..flen-1] as a frame, then add its expected replay to the model
  task automatic send_frame(input logic [1:0] m);
    mode_i = m;
    for (int i = 0; i < flen; i++) begin
      tx_en_i = 1'b1;
      tx_data_i = fb[i];
      mii_cycle();
    end
    tx_en_i = 1'b0;
    tx_data_i = 4'd0;
    mii_cycle();
    t_end = mii_n;
    if (m == 2'd1 || flen > DEPTH) begin
      exp_drop++;
    end else begin
      exp_rx++;
      for (int i = 0; i < flen; i++)
        exp_nib.push_back(fb[i] ^ ((i == flen - 1 && m == 2'd2) ? 4'h1 : 4'h0));
      exp_len.push_back(flen);
    end
  endtask

  task automatic idle(input int n);
    tx_en_i = 1'b0;
    repeat (n) mii_cycle();
  endtask

  task automatic drain();
    int budget;
    budget = 800;
    tx_en_i = 1'b0;
    while ((exp_len.size() != 0 || in_frame) && budget > 0) begin
      mii_cycle();
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d frames outstanding, required 0", exp_len.size());
    end
    idle(int'(ifg_i) + 30);
  endtask

  task automatic check_counters();
    check("frames_rx", 32'(frames_rx_o), 32'(exp_rx));
    check("frames_tx", 32'(frames_tx_o), 32'(exp_tx));
    check("frames_drop", 32'(frames_drop_o), 32'(exp_drop));
    check("busy_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic fill_random(input int n);
    flen = n;
    for (int i = 0; i < n; i++) fb[i] = 4'($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mode: 2'd0, ifg: 8'd12,  len: 8, last_nib: 4'h3, exp_lat: 13,  exp_last: 4'h3, exp_replay: 1'b1};
    tbl[1] = '{mode: 2'd2, ifg: 8'd3,   len: 8, last_nib: 4'hA, exp_lat: 4,   exp_last: 4'hB, exp_replay: 1'b1};
    tbl[2] = '{mode: 2'd2, ifg: 8'd0,   len: 5, last_nib: 4'h1, exp_lat: 2,   exp_last: 4'h0, exp_replay: 1'b1};
    tbl[3] = '{mode: 2'd3, ifg: 8'd1,   len: 4, last_nib: 4'h7, exp_lat: 2,   exp_last: 4'h7, exp_replay: 1'b1};
    tbl[4] = '{mode: 2'd1, ifg: 8'd5,   len: 6, last_nib: 4'h2, exp_lat: 0,   exp_last: 4'h0, exp_replay: 1'b0};
    tbl[5] = '{mode: 2'd0, ifg: 8'd255, len: 3, last_nib: 4'hF, exp_lat: 256, exp_last: 4'hF, exp_replay: 1'b1};

    arst_n_i = 1'b0;
    mode_i = 2'd0;
    ifg_i = 8'd1;
    tx_en_i = 1'b0;
    tx_data_i = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_eth_clk", 32'(eth_clk_o), 32'd0);
    check("rst_rx_dv", 32'(rx_dv_o), 32'd0);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    check("rst_counters", 32'({frames_rx_o, frames_tx_o} | 32'(frames_drop_o)), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    arst_n_i = 1'b1;

    // Divider: after edge k the count is k mod 4, clock high for counts 2..3
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("eth_clk_phase", 32'(eth_clk_o), 32'((k % 4) >= 2));
    end

    // Drop mode: three frames, nothing replayed
    ifg_i = 8'd2;
    fill_random(8);  send_frame(2'd1); idle(3);
    fill_random(12); send_frame(2'd1); idle(3);
    fill_random(5);  send_frame(2'd1);
    drain();
    check("drop3_frames_drop", 32'(frames_drop_o), 32'd3);
    check("drop3_frames_rx", 32'(frames_rx_o), 32'd0);
    check_counters();

    // 64-nibble frame: preamble, SFD, payload, ifg 12
    ifg_i = 8'd12;
    flen = 64;
    for (int i = 0; i < 15; i++) fb[i] = 4'h5;
    fb[15] = 4'hD;
    for (int i = 16; i < 64; i++) fb[i] = 4'($urandom);
    last_first_mii = -1;
    send_frame(2'd0);
    drain();
    check("lat64", 32'(last_first_mii - t_end), 32'd13);
    check("f64_frames_rx", 32'(frames_rx_o), 32'd1);
    check("f64_frames_tx", 32'(frames_tx_o), 32'd1);
    check_counters();

    // Vector table: mode / gap / latency / last-nibble handling
    for (int v = 0; v < 6; v++) begin
      ifg_i = tbl[v].ifg;
      fill_random(tbl[v].len);
      fb[tbl[v].len - 1] = tbl[v].last_nib;
      last_first_mii = -1;
      send_frame(tbl[v].mode);
      drain();
      if (tbl[v].exp_replay) begin
        check("tbl_latency", 32'(last_first_mii - t_end), 32'(tbl[v].exp_lat));
        check("tbl_last_nibble", 32'(last_rx_nib), 32'(tbl[v].exp_last));
      end else begin
        check("tbl_no_replay", 32'(last_first_mii), 32'hFFFF_FFFF);
      end
      check_counters();
    end

    // Overflow: frame larger than the FIFO is dropped, next one survives
    ifg_i = 8'd2;
    fill_random(DEPTH + 6);
    send_frame(2'd0);
    idle(3);
    fill_random(10);
    send_frame(2'd0);
    drain();
    check_counters();

    // Random blocks with overlapping capture and replay
    for (int b = 0; b < 4; b++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      ifg_i = 8'($urandom_range(0, 6));
      for (int f = 0; f < 6; f++) begin
        fill_random(int'($urandom_range(1, 24)));
        send_frame(m);
        idle(int'(ifg_i) + 5 + int'($urandom_range(0, 3)));
      end
      drain();
      check_counters();
    end

    // Reset in the middle of a replay
    ifg_i = 8'd1;
    fill_random(20);
    send_frame(2'd0);
    begin
      int guard;
      guard = 0;
      while (cur_q.size() < 5 && guard < 60) begin
        mii_cycle();
        guard++;
      end
    end
    check("pre_reset_replaying", 32'(rx_dv_o), 32'd1);
    #2 arst_n_i = 1'b0;
    #1;
    check("midrst_rx_dv", 32'(rx_dv_o), 32'd0);
    check("midrst_frames_rx", 32'(frames_rx_o), 32'd0);
    check("midrst_frames_tx", 32'(frames_tx_o), 32'd0);
    check("midrst_frames_drop", 32'(frames_drop_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_eth_clk", 32'(eth_clk_o), 32'd0);
    in_frame = 1'b0;
    cur_q.delete();
    exp_nib.delete();
    exp_len.delete();
    exp_rx = 0;
    exp_tx = 0;
    exp_drop = 0;
    tx_en_i = 1'b1;
    tx_data_i = 4'h9;
    repeat (3) @(negedge clk);
    arst_n_i = 1'b1;
    // Frame already in flight at release must be ignored
    for (int i = 0; i < 6; i++) begin
      tx_data_i = 4'($urandom);
      mii_cycle();
    end
    idle(5);
    fill_random(12);
    send_frame(2'd0);
    drain();
    check("postrst_frames_rx", 32'(frames_rx_o), 32'd1);
    check_counters();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_sim_mii_loopback.md
Name: iob_sim_mii_loopback

Overview:
- Simulation-side MII Ethernet loopback partner for SoC sim wrappers; successor to the fixed 4:1 divided-clock loopback.
- Generates the MII clock from the system clock with a parametrised divide ratio and buffers complete TX frames in a FIFO.
- Replays each frame on RX after a programmable inter-frame gap, with pass, drop or corrupt modes and frame counters for testbench checks.

Parameters:
- CLK_DIV, 4, system clocks per MII clock period; even, >=2.
- FIFO_ADDR_W, 11, FIFO depth 2^FIFO_ADDR_W nibble entries.
- CNT_W, 16, width of statistics counters.

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous active-low reset
- mode_i  in  2  0=loopback, 1=drop all, 2=corrupt (invert bit0 of last nibble), 3=reserved, treated as 0
- ifg_i  in  8  idle MII cycles between replayed frames; 0 means 1
- eth_clk_o  out  1  MII clock, to DUT RX_CLK/TX_CLK
- tx_en_i  in  1  DUT TX_EN
- tx_data_i  in  4  DUT TX_DATA
- rx_dv_o  out  1  to DUT RX_DV
- rx_data_o  out  4  to DUT RX_DATA
- frames_rx_o  out  CNT_W  frames fully captured
- frames_tx_o  out  CNT_W  frames replayed
- frames_drop_o  out  CNT_W  frames discarded (mode 1 or overflow)
- busy_o  out  1  FIFO non-empty or replay in progress

Behaviour:
- Reset: all outputs 0; counters, pointers and divider 0; FSM in IDLE. eth_clk_o is low in reset.
- Clock divider: cnt counts 0..CLK_DIV-1 and wraps. eth_clk_o=1 when cnt>=CLK_DIV/2, driven from a register.
- fall_tick is the cycle with cnt==CLK_DIV-1. All MII sampling and driving happen only on fall_tick, giving half a period of setup before the DUT's rising edge.
- Capture side, on fall_tick with tx_en_i=1:
  - Write {last=0, tx_data_i} at wr_ptr and advance.
  - First nibble of a frame records frame_start=wr_ptr.
- End of frame, on fall_tick where tx_en_i falls 1->0:
  - Set the last flag on the final written entry, commit the frame (commit_ptr=wr_ptr) and increment frames_rx_o.
  - In mode 1, roll wr_ptr back to frame_start instead of committing, and increment frames_drop_o rather than frames_rx_o.
- Overflow: a write while full marks the frame bad. Remaining nibbles are ignored, and at frame end wr_ptr rolls back to frame_start and frames_drop_o increments. The replay FIFO never holds partial frames.
- Replay FSM, transitions evaluated on fall_tick only:
  - IDLE -> GAP when rd_ptr!=commit_ptr; load gap counter with max(ifg_i,1).
  - GAP: decrement; at 1 -> SEND.
  - SEND: rx_dv_o=1, rx_data_o=entry at rd_ptr, advance rd_ptr. In mode 2, invert bit0 of rx_data_o on the entry with last=1. The last entry's next fall_tick -> IDLE with rx_dv_o=0, and frames_tx_o increments.
  - Back-to-back frames still pass through GAP.
- Simultaneous capture and replay is allowed (independent pointers). Pointers wrap at 2^FIFO_ADDR_W, and full/empty use an extra wrap bit.
- Counters wrap at 2^CNT_W.
- A mode_i change takes effect at the next frame start (capture) and the next SEND entry (replay). A frame in flight keeps its mode.
- Reset mid-frame: asserting arst_n_i immediately clears everything. After release, a DUT frame already in progress (tx_en_i high) is ignored until tx_en_i is seen low.
- Latency: first RX nibble appears max(ifg_i,1)+1 MII cycles after the fall_tick that sampled tx_en_i low.
- busy_o = (rd_ptr!=commit_ptr) | (state!=IDLE) | capturing.

Test Plan:
- CLK_DIV=4, reset release: eth_clk_o period 4 clk_i, high for cycles 2-3 of each period, outputs 0 → divider and reset values correct.
- Mode 0, ifg_i=12, 64-nibble frame 0x5..5,0xD,payload: identical 64 nibbles on rx_data_o with rx_dv_o high exactly 64 MII cycles, starting 13 MII cycles after TX_EN low. frames_rx_o=1, frames_tx_o=1.
- Mode 2, 8-nibble frame ending 0xA: last RX nibble 0xB, others unchanged.
- Mode 1, three frames: rx_dv_o never asserts, frames_drop_o=3, frames_rx_o=0, busy_o returns 0.
- FIFO_ADDR_W=4, 20-nibble frame then a 10-nibble frame: first dropped (frames_drop_o=1), second replayed intact. No partial frame on RX.
- Reset asserted mid-replay: rx_dv_o=0 and counters 0 immediately. After release, a TX frame already in progress is not captured, and the next full frame loops back correctly.
